// File: rtl/vga_ram_arbiter.sv
// Arbitrates a single-port, 1-cycle-latency RAM between the never-stalled VGA
// display reader (absolute priority) and a req/ack host port that fills idle cycles.
module vga_ram_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              host_starved,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic {IDLE, ACK} state_t;

  state_t           state, state_next;
  logic             host_grant;
  logic [CNT_W-1:0] wait_cnt, wait_next;
  logic             disp_pend;
  logic             host_rd_pend;

  // ACK blocks a second grant while the host is still looking at its ack pulse
  always_comb begin
    state_next = state;
    host_grant = 1'b0;
    wait_next  = wait_cnt;
    case (state)
      IDLE: begin
        if (!disp_req && host_req) begin
          host_grant = 1'b1;
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (host_grant || !host_req)
      wait_next = '0;
    else if (state == IDLE && wait_cnt < WAIT_MAX)
      wait_next = wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      host_ack     <= 1'b0;
      disp_pend    <= 1'b0;
      disp_rvalid  <= 1'b0;
      host_rd_pend <= 1'b0;
      host_rvalid  <= 1'b0;
      wait_cnt     <= '0;
      host_starved <= 1'b0;
    end else begin
      state  <= state_next;
      mem_we <= 1'b0;
      if (disp_req) begin
        mem_addr <= disp_addr;
      end else if (host_grant) begin
        mem_addr  <= host_addr;
        mem_we    <= host_we;
        mem_wdata <= host_wdata;
      end
      host_ack     <= host_grant;
      // One stage to present the address, one for the RAM read latency
      disp_pend    <= disp_req;
      disp_rvalid  <= disp_pend;
      host_rd_pend <= host_grant & ~host_we;
      host_rvalid  <= host_rd_pend;
      wait_cnt     <= wait_next;
      host_starved <= (wait_cnt >= WAIT_MAX);
    end
  end

  assign disp_rdata = mem_rdata;
  assign host_rdata = mem_rdata;

endmodule

// File: tb/tb_vga_ram_arbiter.sv
// Self-checking bench for vga_ram_arbiter: vector table, directed corner sequences
// and randomized traffic checked against an event-scheduling reference model.
module tb_vga_ram_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int MW = 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          disp_rvalid;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic          host_starved;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  vga_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata),
    .disp_rvalid(disp_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .host_starved(host_starved),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return DW'(a) ^ 8'h5A;
  endfunction

  // Behavioural RAM: unwritten locations read back a fixed address pattern
  bit [DW-1:0] ram [DEPTH];
  bit          written [DEPTH];
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    mem_rdata <= written[mem_addr] ? ram[mem_addr] : pattern(mem_addr);
  end

  int test_count = 0;
  int fail_count = 0;

  // Reference model: grants are scheduled events, data comes from a shadow memory
  int            cyc = 0;
  int            last_grant;
  int            wait_count;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_ddata, e_hdata;
  logic          e_we, e_ack, e_drv, e_hrv, e_starved;
  int            d_due[$];
  logic [DW-1:0] d_dat[$];
  int            h_due[$];
  logic [DW-1:0] h_dat[$];
  logic [DW-1:0] shadow [DEPTH];

  task automatic modelEdge();
    bit host_free, granted;
    cyc++;
    if (rst) begin
      last_grant = -100;
      wait_count = 0;
      d_due.delete(); d_dat.delete(); h_due.delete(); h_dat.delete();
      e_addr = '0; e_we = 0; e_wdata = '0; e_ack = 0;
      e_drv = 0; e_hrv = 0; e_starved = 0;
    end else begin
      host_free = (cyc - last_grant) >= 2;
      granted   = 0;
      e_starved = (wait_count >= MW);
      e_ack     = 0;
      e_we      = 0;
      if (disp_req) begin
        e_addr = disp_addr;
        d_due.push_back(cyc + 1);
        d_dat.push_back(shadow[disp_addr]);
      end else if (host_req && host_free) begin
        granted    = 1;
        last_grant = cyc;
        e_ack      = 1;
        e_addr     = host_addr;
        e_we       = host_we;
        e_wdata    = host_wdata;
        if (host_we) shadow[host_addr] = host_wdata;
        else begin
          h_due.push_back(cyc + 1);
          h_dat.push_back(shadow[host_addr]);
        end
      end
      if (granted || !host_req) wait_count = 0;
      else if (host_free) wait_count = (wait_count < MW) ? wait_count + 1 : MW;
      e_drv = 0;
      if (d_due.size() > 0 && d_due[0] == cyc) begin
        e_drv = 1;
        void'(d_due.pop_front());
        e_ddata = d_dat.pop_front();
      end
      e_hrv = 0;
      if (h_due.size() > 0 && h_due[0] == cyc) begin
        e_hrv = 1;
        void'(h_due.pop_front());
        e_hdata = h_dat.pop_front();
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic checkModel();
    checkOutput("host_ack", 32'(host_ack), 32'(e_ack));
    checkOutput("disp_rvalid", 32'(disp_rvalid), 32'(e_drv));
    checkOutput("host_rvalid", 32'(host_rvalid), 32'(e_hrv));
    checkOutput("host_starved", 32'(host_starved), 32'(e_starved));
    checkOutput("mem_we", 32'(mem_we), 32'(e_we));
    checkOutput("mem_addr", 32'(mem_addr), 32'(e_addr));
    checkOutput("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    checkOutput("rvalid_excl", 32'(disp_rvalid & host_rvalid), 32'(0));
    if (e_drv) checkOutput("disp_rdata", 32'(disp_rdata), 32'(e_ddata));
    if (e_hrv) checkOutput("host_rdata", 32'(host_rdata), 32'(e_hdata));
  endtask

  // Drive one cycle of inputs, clock it, then sample 1 time unit after the edge
  task automatic applyStimulus(input logic r, input logic dr, input logic [AW-1:0] da,
                               input logic hr, input logic hw, input logic [AW-1:0] ha,
                               input logic [DW-1:0] hd);
    rst = r; disp_req = dr; disp_addr = da;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    @(posedge clk);
    modelEdge();
    #1;
    checkModel();
  endtask

  typedef struct {
    logic          r, dreq;
    logic [AW-1:0] daddr;
    logic          hreq, hwe;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwd;
    logic          ack, drv, hrv, we, starved;
    logic [AW-1:0] maddr;
    logic          chk_data;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t vecs[11];

  int ack_count, consec, prev_ack;
  logic          h_req, h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wd;
  logic          r_now, r_prev, d_now;

  initial begin
    //        r  dreq daddr    hreq hwe haddr   hwd    ack drv hrv we st  maddr  chk rdata
    vecs[0]  = '{1, 1, 11'h005, 1, 1, 11'h040, 8'hA5, 0, 0, 0, 0, 0, 11'h000, 0, 8'h00};
    vecs[1]  = '{1, 1, 11'h123, 1, 0, 11'h7FF, 8'h3C, 0, 0, 0, 0, 0, 11'h000, 0, 8'h00};
    vecs[2]  = '{0, 1, 11'h005, 1, 1, 11'h040, 8'hA5, 0, 0, 0, 0, 0, 11'h005, 0, 8'h00};
    vecs[3]  = '{0, 0, 11'h000, 1, 1, 11'h040, 8'hA5, 1, 1, 0, 1, 0, 11'h040, 1, 8'h5F};
    vecs[4]  = '{0, 0, 11'h000, 1, 1, 11'h040, 8'hA5, 0, 0, 0, 0, 0, 11'h040, 0, 8'h00};
    vecs[5]  = '{0, 0, 11'h000, 1, 1, 11'h040, 8'hA5, 1, 0, 0, 1, 0, 11'h040, 0, 8'h00};
    vecs[6]  = '{0, 0, 11'h000, 0, 0, 11'h000, 8'h00, 0, 0, 0, 0, 0, 11'h040, 0, 8'h00};
    vecs[7]  = '{0, 0, 11'h000, 1, 0, 11'h040, 8'h00, 1, 0, 0, 0, 0, 11'h040, 0, 8'h00};
    vecs[8]  = '{0, 1, 11'h041, 0, 0, 11'h000, 8'h00, 0, 0, 1, 0, 0, 11'h041, 1, 8'hA5};
    vecs[9]  = '{0, 0, 11'h000, 0, 0, 11'h000, 8'h00, 0, 1, 0, 0, 0, 11'h041, 1, 8'h1B};
    vecs[10] = '{0, 0, 11'h000, 0, 0, 11'h000, 8'h00, 0, 0, 0, 0, 0, 11'h041, 0, 8'h00};

    for (int i = 0; i < DEPTH; i++) shadow[i] = pattern(AW'(i));
    last_grant = -100;
    wait_count = 0;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].r, vecs[i].dreq, vecs[i].daddr, vecs[i].hreq,
                    vecs[i].hwe, vecs[i].haddr, vecs[i].hwd);
      checkOutput($sformatf("v%0d_ack", i), 32'(host_ack), 32'(vecs[i].ack));
      checkOutput($sformatf("v%0d_drv", i), 32'(disp_rvalid), 32'(vecs[i].drv));
      checkOutput($sformatf("v%0d_hrv", i), 32'(host_rvalid), 32'(vecs[i].hrv));
      checkOutput($sformatf("v%0d_we", i), 32'(mem_we), 32'(vecs[i].we));
      checkOutput($sformatf("v%0d_starved", i), 32'(host_starved), 32'(vecs[i].starved));
      checkOutput($sformatf("v%0d_maddr", i), 32'(mem_addr), 32'(vecs[i].maddr));
      if (vecs[i].chk_data)
        checkOutput($sformatf("v%0d_rdata", i),
                    32'(vecs[i].hrv ? host_rdata : disp_rdata), 32'(vecs[i].rdata));
    end

    // Display streaming: consecutive addresses, rvalid continuous once the pipe fills
    for (int a = 0; a < 128; a++) begin
      applyStimulus(0, 1, AW'(a), 0, 0, '0, '0);
      checkOutput("stream_maddr", 32'(mem_addr), 32'(a));
      checkOutput("stream_we", 32'(mem_we), 32'(0));
      if (a >= 1) checkOutput("stream_rvalid", 32'(disp_rvalid), 32'(1));
    end

    // Host held pending under 20 display cycles, granted on the first free cycle
    ack_count = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 1, AW'($urandom_range(DEPTH - 1)), 1, 0, 11'h010, '0);
      ack_count += int'(host_ack);
    end
    checkOutput("collision_no_ack", 32'(ack_count), 32'(0));
    applyStimulus(0, 0, '0, 1, 0, 11'h010, '0);
    checkOutput("collision_ack", 32'(host_ack), 32'(1));
    applyStimulus(0, 0, '0, 0, 0, '0, '0);
    applyStimulus(0, 0, '0, 0, 0, '0, '0);

    // Back-to-back host requests: one access per two cycles
    ack_count = 0; consec = 0; prev_ack = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 0, '0, 1, 1, 11'h020, 8'h3C);
      if (host_ack && prev_ack != 0) consec++;
      prev_ack = int'(host_ack);
      ack_count += int'(host_ack);
    end
    checkOutput("b2b_acks", 32'(ack_count), 32'(10));
    checkOutput("b2b_consec", 32'(consec), 32'(0));

    // Starvation: random inputs under reset, then a permanently busy display
    for (int k = 0; k < 2; k++)
      applyStimulus(1, 1'($urandom), AW'($urandom), 1'($urandom), 1'($urandom),
                    AW'($urandom), DW'($urandom));
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(0, 1, AW'(k), 1, 0, 11'h030, '0);
      checkOutput($sformatf("starve_k%0d", k), 32'(host_starved), 32'(k >= 9));
    end
    applyStimulus(0, 0, '0, 1, 0, 11'h030, '0);
    checkOutput("starve_grant", 32'(host_ack), 32'(1));
    checkOutput("starve_hold", 32'(host_starved), 32'(1));
    applyStimulus(0, 0, '0, 0, 0, '0, '0);
    checkOutput("starve_clear", 32'(host_starved), 32'(0));

    // Randomized traffic with active/blanking display phases and rare resets
    h_req = 0; h_we = 0; h_addr = '0; h_wd = '0; r_prev = 0;
    for (int k = 0; k < 3000; k++) begin
      if (r_prev) h_req = 0;
      else if (h_req && host_ack) begin
        if ($urandom_range(3) != 0) h_req = 0;
      end else if (!h_req && $urandom_range(2) == 0) begin
        h_req  = 1;
        h_we   = 1'($urandom_range(1));
        h_addr = AW'($urandom_range(63));
        h_wd   = DW'($urandom);
      end
      d_now = ((k % 50) < 35) ? ($urandom_range(9) != 0) : ($urandom_range(9) == 0);
      r_now = ($urandom_range(499) == 0);
      applyStimulus(r_now, d_now, AW'($urandom_range(127)), h_req, h_we, h_addr, h_wd);
      r_prev = r_now;
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
